// File: rtl/imem_sram_responder_pkg.sv
// Shared types and helpers for the SRAM responder.
//   resp_state_t    : responder FSM states (IDLE waits for a request,
//                     WAIT counts down the wait states of the current request)
//   MAX_WAIT_STATES : largest supported WAIT_STATES value (cnt is 4 bits wide)
//   be_to_bwen()    : expands active-high byte enables into the active-low
//                     per-bit write mask of the macro
package ram_resp_pkg;

  localparam int MAX_WAIT_STATES = 15;

  // Widest data path supported by be_to_bwen; callers cast the result down.
  localparam int MAX_DW = 512;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  function automatic logic [MAX_DW-1:0] be_to_bwen(input logic [MAX_DW/8-1:0] be);
    logic [MAX_DW-1:0] mask;
    for (int i = 0; i < MAX_DW / 8; i++) begin
      mask[8*i +: 8] = {8{~be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/imem_sram_responder_if.sv
// Ram_if request/response bundle between a client (master) and the
// memory-side responder (slave).
//   en/addr/we/be/data_w : request from the client
//   data_r               : read data, held until the next read response
//   delay                : stall from the responder
//   err                  : one-cycle pulse after an out-of-range request
//
// Handshake: a request is offered by raising en with addr/we/be/data_w valid.
// It is accepted on a rising clk edge where en=1 and delay=0. While delay=1
// the client must keep en high and the request fields unchanged; dropping en
// during a stall abandons the request without any memory side effect.
interface imem_sram_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                    en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data_w;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    delay;
  logic                    err;

  modport master (
    output en, addr, we, be, data_w,
    input  data_r, delay, err
  );

  modport slave (
    input  en, addr, we, be, data_w,
    output data_r, delay, err
  );

endinterface

// File: rtl/imem_sram_responder_hold.sv
// Read-response path of the SRAM responder.
//   clk, reset  : clock and synchronous active-high reset
//   rd_accept   : a read is accepted this cycle
//   rd_in_range : the accepted read targets an existing macro word
//   sram_q      : macro read data (valid the cycle after the read edge)
//   data_r      : read data towards the client
// In the response cycle data_r comes straight from the macro (or zero for an
// out-of-range read) and the same value is captured, so data_r stays stable
// until the next read response.
module ram_resp_hold #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_accept,
  input  logic                  rd_in_range,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic [DATA_WIDTH-1:0] data_r
);

  logic                  rsp_valid;
  logic                  rsp_in_range;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign rsp_data = rsp_in_range ? sram_q : '0;
  assign data_r   = rsp_valid ? rsp_data : hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_in_range <= 1'b0;
      hold_q       <= '0;
    end else begin
      rsp_valid    <= rd_accept;
      rsp_in_range <= rd_in_range;
      if (rsp_valid) begin
        hold_q <= rsp_data;
      end
    end
  end

endmodule

// File: rtl/imem_sram_responder.sv
// Memory-side endpoint of the Ram_if protocol driving one single-port SRAM
// macro with active-low controls.
//   clk, reset : clock and synchronous active-high reset
//   bus        : Ram_if slave (en/addr/we/be/data_w in, data_r/delay/err out)
//   sram_csn   : chip select, active-low
//   sram_wen   : write enable, active-low
//   sram_bwen  : per-bit write mask, active-low
//   sram_a     : macro word address
//   sram_d     : macro write data
//   sram_q     : macro read data, one cycle after a read edge
//   state_dbg  : current FSM state (0 = IDLE, 1 = WAIT)
// Each request is stalled for WAIT_STATES cycles before acceptance. Requests
// outside the macro never touch it and raise err one cycle after acceptance.
module imem_sram_responder
  import ram_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SRAM_DEPTH  = 4096,
  parameter int WAIT_STATES = 0,
  parameter int SRAM_AW     = $clog2(SRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_sram_responder_if.slave  bus,
  output logic                  sram_csn,
  output logic                  sram_wen,
  output logic [DATA_WIDTH-1:0] sram_bwen,
  output logic [SRAM_AW-1:0]    sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic [0:0]            state_dbg
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_WAIT = WAIT;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [0:0] state;
  logic [3:0] cnt;
  logic       stall;
  logic       accept;
  logic       in_range;
  logic       err_q;

  // Extra MSB keeps the compare correct when SRAM_DEPTH equals 2**ADDR_WIDTH.
  assign in_range = ({1'b0, bus.addr} < (ADDR_WIDTH + 1)'(SRAM_DEPTH));

  // In IDLE the first request cycle already stalls when wait states exist;
  // in WAIT the stall lasts until the countdown reaches zero.
  always_comb begin
    stall = 1'b0;
    if (bus.en) begin
      if (state == S_IDLE) begin
        stall = (WAIT_STATES != 0);
      end else begin
        stall = (cnt != 4'd0);
      end
    end
  end

  assign bus.delay = stall && !reset;
  assign accept    = bus.en && !stall && !reset;
  assign bus.err   = err_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      if (state == S_IDLE) begin
        if (bus.en && (WAIT_STATES != 0)) begin
          state <= S_WAIT;
          cnt   <= WS - 4'd1;
        end
      end else begin
        // Dropping en mid-stall abandons the request without acceptance.
        if (!bus.en || (cnt == 4'd0)) begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Chip select stays low through the wait states so the macro keeps reading
  // the held address; the last read edge is the acceptance edge.
  assign sram_csn  = !(bus.en && in_range && !reset);
  assign sram_wen  = !(accept && bus.we && in_range);
  assign sram_bwen = reset ? '1 : DATA_WIDTH'(be_to_bwen((MAX_DW / 8)'(bus.be)));
  assign sram_a    = bus.addr[SRAM_AW-1:0];
  assign sram_d    = bus.data_w;

  ram_resp_hold #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .rd_accept   (accept && !bus.we),
    .rd_in_range (in_range),
    .sram_q      (sram_q),
    .data_r      (bus.data_r)
  );

endmodule

// File: tb/tb_imem_sram_responder.sv
// Bench for imem_sram_responder: one instance with no wait states (dut0) and
// one with three (dut3), each backed by its own behavioural SRAM macro.
module tb_imem_sram_responder;
  import ram_resp_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int SAW   = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_sram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  imem_sram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if3 ();

  logic          csn0, wen0, csn3, wen3;
  logic [DW-1:0] bwen0, d0, q0, bwen3, d3, q3;
  logic [SAW-1:0] a0, a3;
  logic [0:0]    st0, st3;

  imem_sram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .sram_csn(csn0), .sram_wen(wen0),
    .sram_bwen(bwen0), .sram_a(a0), .sram_d(d0), .sram_q(q0), .state_dbg(st0)
  );

  imem_sram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave), .sram_csn(csn3), .sram_wen(wen3),
    .sram_bwen(bwen3), .sram_a(a3), .sram_d(d3), .sram_q(q3), .state_dbg(st3)
  );

  // ---------------- SRAM macro models ----------------
  logic [DW-1:0] mem0 [0:DEPTH-1];
  logic [DW-1:0] mem3 [0:DEPTH-1];
  logic          mem_init;
  logic [DW-1:0] seed;

  function automatic logic [DW-1:0] init_word(input int i, input logic [DW-1:0] s);
    logic [DW-1:0] ii;
    ii = 32'(i);
    return (ii * 32'h9E37_79B9) ^ s;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem0[i] <= init_word(i, seed);
    end else if (!csn0) begin
      if (!wen0) mem0[a0] <= (mem0[a0] & bwen0) | (d0 & ~bwen0);
      else       q0 <= mem0[a0];
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem3[i] <= init_word(i, seed);
    end else if (!csn3) begin
      if (!wen3) mem3[a3] <= (mem3[a3] & bwen3) | (d3 & ~bwen3);
      else       q3 <= mem3[a3];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref0 [0:DEPTH-1];
  logic [DW-1:0] ref3 [0:DEPTH-1];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q3[$];
  logic [DW-1:0] hold0, hold3;
  logic          rd_pend0, err_pend0, rd_pend3, err_pend3;

  int n_checks = 0;
  int n_fail   = 0;

  // observed / expected values of the last dut0 cycle
  logic          o_delay, o_err, o_csn, o_wen;
  logic [DW-1:0] o_bwen, o_data;
  logic [SAW-1:0] o_a;
  logic          e_delay, e_err, e_csn, e_wen;
  logic [DW-1:0] e_data;

  // results of the last dut3 transaction / idle cycle
  int            r_ndel, r_ncsn, r_nwen, r_wen_cyc, r_acc;
  logic [19:0]   r_delmask;
  logic [DW-1:0] o3_first_data, e3_first_data, o3_idata, e3_idata;
  logic          o3_first_err, e3_first_err, o3_ierr, e3_ierr;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < DW / 8; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic clear_models();
    hold0 = '0; rd_pend0 = 1'b0; err_pend0 = 1'b0; exp_q0.delete();
    hold3 = '0; rd_pend3 = 1'b0; err_pend3 = 1'b0; exp_q3.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One dut0 cycle: drive request, sample at negedge, advance the model.
  task automatic cyc0(input logic en, input logic we, input logic [AW-1:0] addr,
                      input logic [DW/8-1:0] be, input logic [DW-1:0] d);
    logic inr;
    if0.en = en; if0.we = we; if0.addr = addr; if0.be = be; if0.data_w = d;
    inr = (addr < DEPTH);
    e_delay = 1'b0;
    e_csn   = !(en && inr);
    e_wen   = !(en && we && inr);
    e_err   = err_pend0;
    if (rd_pend0) hold0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : 'x;
    e_data  = hold0;
    @(negedge clk);
    o_delay = if0.delay; o_err = if0.err; o_csn = csn0; o_wen = wen0;
    o_bwen = bwen0; o_data = if0.data_r; o_a = a0;
    err_pend0 = en && !inr;
    rd_pend0  = en && !we;
    if (en && !we) exp_q0.push_back(inr ? ref0[addr[SAW-1:0]] : '0);
    if (en && we && inr) ref0[addr[SAW-1:0]] = merge_bytes(ref0[addr[SAW-1:0]], d, be);
    @(posedge clk); #1;
  endtask

  // One full dut3 request, held until accepted (bounded at 20 cycles).
  task automatic req3(input logic we, input logic [AW-1:0] addr,
                      input logic [DW/8-1:0] be, input logic [DW-1:0] d);
    logic inr, done;
    if0.en = 1'b0;
    if3.en = 1'b1; if3.we = we; if3.addr = addr; if3.be = be; if3.data_w = d;
    inr = (addr < DEPTH);
    if (rd_pend3) hold3 = (exp_q3.size() != 0) ? exp_q3.pop_front() : 'x;
    e3_first_data = hold3;
    e3_first_err  = err_pend3;
    r_ndel = 0; r_ncsn = 0; r_nwen = 0; r_wen_cyc = -1; r_acc = -1; r_delmask = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin o3_first_data = if3.data_r; o3_first_err = if3.err; end
      if (if3.delay === 1'b1) begin r_ndel++; r_delmask[c] = 1'b1; end
      if (csn3 === 1'b0) r_ncsn++;
      if (wen3 === 1'b0) begin r_nwen++; r_wen_cyc = c; end
      done = (if3.delay === 1'b0);
      @(posedge clk); #1;
      if (done) begin r_acc = c; break; end
    end
    if3.en = 1'b0;
    err_pend3 = !inr;
    rd_pend3  = !we;
    if (!we) exp_q3.push_back(inr ? ref3[addr[SAW-1:0]] : '0);
    if (we && inr) ref3[addr[SAW-1:0]] = merge_bytes(ref3[addr[SAW-1:0]], d, be);
  endtask

  task automatic idle3();
    if3.en = 1'b0;
    if (rd_pend3) hold3 = (exp_q3.size() != 0) ? exp_q3.pop_front() : 'x;
    e3_idata = hold3;
    e3_ierr  = err_pend3;
    @(negedge clk);
    o3_idata = if3.data_r; o3_ierr = if3.err;
    rd_pend3 = 1'b0; err_pend3 = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    if0.en = 1'b0;
    if3.en = 1'b1; if3.we = 1'b1; if3.addr = 32'd3; if3.be = 4'hF; if3.data_w = $urandom;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (csn3 !== 1'b1) begin n_fail++; $display("FAIL rst_csn: got %b exp 1", csn3); end
    n_checks++; if (wen3 !== 1'b1) begin n_fail++; $display("FAIL rst_wen: got %b exp 1", wen3); end
    n_checks++; if (bwen3 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_bwen: got %h exp ffffffff", bwen3); end
    n_checks++; if (if3.delay !== 1'b0) begin n_fail++; $display("FAIL rst_delay: got %b exp 0", if3.delay); end
    @(posedge clk); #1;
    reset = 1'b0;
    if3.en = 1'b0;
    clear_models();
    n_checks++; if (st0 !== IDLE) begin n_fail++; $display("FAIL rst_state: got %b exp %b", st0, IDLE); end
    for (int i = 0; i < 10; i++) begin
      cyc0(1'b0, 1'b0, '0, '0, '0);
      n_checks++; if (o_delay !== 1'b0) begin n_fail++; $display("FAIL idle_delay c%0d: got %b exp 0", i, o_delay); end
      n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL idle_err c%0d: got %b exp 0", i, o_err); end
      n_checks++; if (o_csn !== 1'b1) begin n_fail++; $display("FAIL idle_csn c%0d: got %b exp 1", i, o_csn); end
      n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL idle_data c%0d: got %h exp 0", i, o_data); end
    end
  endtask

  task automatic test_write_read();
    cyc0(1'b1, 1'b1, 32'd5, 4'hF, 32'hDEAD_BEEF);
    n_checks++; if (o_wen !== 1'b0) begin n_fail++; $display("FAIL wr_wen: got %b exp 0", o_wen); end
    n_checks++; if (o_csn !== 1'b0) begin n_fail++; $display("FAIL wr_csn: got %b exp 0", o_csn); end
    n_checks++; if (o_delay !== 1'b0) begin n_fail++; $display("FAIL wr_delay: got %b exp 0", o_delay); end
    cyc0(1'b1, 1'b0, 32'd5, 4'h0, '0);
    n_checks++; if (o_wen !== 1'b1) begin n_fail++; $display("FAIL rd_wen: got %b exp 1", o_wen); end
    for (int i = 0; i < 6; i++) begin
      cyc0(1'b0, 1'b0, '0, '0, '0);
      n_checks++; if (o_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_hold c%0d: got %h exp deadbeef", i, o_data); end
    end
  endtask

  task automatic test_partial_write();
    cyc0(1'b1, 1'b1, 32'd5, 4'b0010, 32'h0000_AA00);
    n_checks++; if (o_bwen !== 32'hFFFF_00FF) begin n_fail++; $display("FAIL part_bwen: got %h exp ffff00ff", o_bwen); end
    n_checks++; if (o_wen !== 1'b0) begin n_fail++; $display("FAIL part_wen: got %b exp 0", o_wen); end
    cyc0(1'b1, 1'b0, 32'd5, 4'h0, '0);
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_data !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL part_data: got %h exp deadaaef", o_data); end
    // empty byte mask: accepted, nothing modified
    cyc0(1'b1, 1'b1, 32'd5, 4'h0, 32'h1111_1111);
    n_checks++; if (o_bwen !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL be0_bwen: got %h exp ffffffff", o_bwen); end
    cyc0(1'b1, 1'b0, 32'd5, 4'h0, '0);
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_data !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL be0_data: got %h exp deadaaef", o_data); end
  endtask

  task automatic test_back_to_back();
    cyc0(1'b1, 1'b0, 32'd5, 4'h0, '0);
    cyc0(1'b1, 1'b1, 32'd5, 4'hF, 32'h1234_5678);
    n_checks++; if (o_data !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL rw_prewrite: got %h exp deadaaef", o_data); end
    cyc0(1'b1, 1'b0, 32'd5, 4'h0, '0);
    cyc0(1'b1, 1'b0, 32'd6, 4'h0, '0);
    n_checks++; if (o_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_then_rd: got %h exp 12345678", o_data); end
    cyc0(1'b1, 1'b0, 32'd7, 4'h0, '0);
    n_checks++; if (o_data !== e_data) begin n_fail++; $display("FAIL rr_first: got %h exp %h", o_data, e_data); end
    n_checks++; if (o_a !== 12'd7) begin n_fail++; $display("FAIL rr_addr: got %0d exp 7", o_a); end
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_data !== e_data) begin n_fail++; $display("FAIL rr_second: got %h exp %h", o_data, e_data); end
  endtask

  task automatic test_out_of_range();
    cyc0(1'b1, 1'b1, 32'd4096, 4'hF, 32'hCAFE_F00D);
    n_checks++; if (o_wen !== 1'b1) begin n_fail++; $display("FAIL oor_wen: got %b exp 1", o_wen); end
    n_checks++; if (o_csn !== 1'b1) begin n_fail++; $display("FAIL oor_csn: got %b exp 1", o_csn); end
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b exp 1", o_err); end
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_end: got %b exp 0", o_err); end
    cyc0(1'b1, 1'b0, 32'd5000, 4'h0, '0);
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h exp 0", o_data); end
    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL oor_rerr: got %b exp 1", o_err); end
    cyc0(1'b0, 1'b0, '0, '0, '0);
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL oor_rhold: got %h exp 0", o_data); end
    // same on the wait-state instance
    req3(1'b1, 32'd4096, 4'hF, 32'hCAFE_F00D);
    n_checks++; if (r_nwen != 0) begin n_fail++; $display("FAIL oor3_wen: got %0d exp 0", r_nwen); end
    n_checks++; if (r_ncsn != 0) begin n_fail++; $display("FAIL oor3_csn: got %0d exp 0", r_ncsn); end
    idle3();
    n_checks++; if (o3_ierr !== 1'b1) begin n_fail++; $display("FAIL oor3_err: got %b exp 1", o3_ierr); end
  endtask

  task automatic test_random0();
    logic en, we; logic [AW-1:0] addr;
    for (int i = 0; i < 60; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4096, 4200)) : 32'($urandom_range(0, 15));
      cyc0(en, we, addr, 4'($urandom_range(0, 15)), $urandom);
      n_checks++; if (o_delay !== e_delay) begin n_fail++; $display("FAIL rnd_delay c%0d: got %b exp %b", i, o_delay, e_delay); end
      n_checks++; if (o_csn !== e_csn) begin n_fail++; $display("FAIL rnd_csn c%0d: got %b exp %b", i, o_csn, e_csn); end
      n_checks++; if (o_wen !== e_wen) begin n_fail++; $display("FAIL rnd_wen c%0d: got %b exp %b", i, o_wen, e_wen); end
      n_checks++; if (o_err !== e_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b exp %b", i, o_err, e_err); end
      n_checks++; if (o_data !== e_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h exp %h", i, o_data, e_data); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc0(1'b0, 1'b0, '0, '0, '0);
      n_checks++; if (o_data !== e_data) begin n_fail++; $display("FAIL rnd_tail c%0d: got %h exp %h", i, o_data, e_data); end
      n_checks++; if (o_err !== e_err) begin n_fail++; $display("FAIL rnd_tail_err c%0d: got %b exp %b", i, o_err, e_err); end
    end
  endtask

  task automatic test_wait_states();
    logic [DW-1:0] wd;
    logic inr, we; logic [AW-1:0] addr;
    req3(1'b0, 32'd7, 4'h0, '0);
    n_checks++; if (r_delmask !== 20'h00007) begin n_fail++; $display("FAIL ws_delmask: got %h exp 00007", r_delmask); end
    n_checks++; if (r_acc != 3) begin n_fail++; $display("FAIL ws_accept: got %0d exp 3", r_acc); end
    n_checks++; if (r_ncsn != 4) begin n_fail++; $display("FAIL ws_csn: got %0d exp 4", r_ncsn); end
    idle3();
    n_checks++; if (o3_idata !== e3_idata) begin n_fail++; $display("FAIL ws_rdata: got %h exp %h", o3_idata, e3_idata); end
    wd = $urandom;
    req3(1'b1, 32'd9, 4'hF, wd);
    n_checks++; if (r_nwen != 1 || r_wen_cyc != 3) begin n_fail++; $display("FAIL ws_wen: got %0d@%0d exp 1@3", r_nwen, r_wen_cyc); end
    req3(1'b0, 32'd9, 4'h0, '0);
    idle3();
    n_checks++; if (o3_idata !== wd) begin n_fail++; $display("FAIL ws_wr_rd: got %h exp %h", o3_idata, wd); end
    for (int i = 0; i < 8; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(4096, 9000)) : 32'($urandom_range(0, 15));
      inr  = (addr < DEPTH);
      req3(we, addr, 4'($urandom_range(0, 15)), $urandom);
      n_checks++; if (r_acc != 3 || r_ndel != 3) begin n_fail++; $display("FAIL ws_rnd_timing r%0d: got acc %0d del %0d exp 3 3", i, r_acc, r_ndel); end
      n_checks++; if (r_ncsn != (inr ? 4 : 0)) begin n_fail++; $display("FAIL ws_rnd_csn r%0d: got %0d exp %0d", i, r_ncsn, inr ? 4 : 0); end
      n_checks++; if (r_nwen != ((we && inr) ? 1 : 0)) begin n_fail++; $display("FAIL ws_rnd_wen r%0d: got %0d", i, r_nwen); end
      n_checks++; if (o3_first_data !== e3_first_data) begin n_fail++; $display("FAIL ws_rnd_data r%0d: got %h exp %h", i, o3_first_data, e3_first_data); end
      n_checks++; if (o3_first_err !== e3_first_err) begin n_fail++; $display("FAIL ws_rnd_err r%0d: got %b exp %b", i, o3_first_err, e3_first_err); end
    end
    idle3();
    n_checks++; if (o3_idata !== e3_idata) begin n_fail++; $display("FAIL ws_rnd_tail: got %h exp %h", o3_idata, e3_idata); end
  endtask

  task automatic test_reset_mid_wait();
    logic [DW-1:0] old_w;
    logic wen_seen;
    old_w = ref3[11];
    wen_seen = 1'b0;
    if0.en = 1'b0;
    if3.en = 1'b1; if3.we = 1'b1; if3.addr = 32'd11; if3.be = 4'hF; if3.data_w = ~old_w;
    @(negedge clk);
    n_checks++; if (if3.delay !== 1'b1) begin n_fail++; $display("FAIL rmw_delay1: got %b exp 1", if3.delay); end
    if (wen3 === 1'b0) wen_seen = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    if (wen3 === 1'b0) wen_seen = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if3.en = 1'b0;
    clear_models();
    @(negedge clk);
    if (wen3 === 1'b0) wen_seen = 1'b1;
    n_checks++; if (if3.delay !== 1'b0) begin n_fail++; $display("FAIL rmw_delay_after: got %b exp 0", if3.delay); end
    n_checks++; if (if3.data_r !== 32'h0) begin n_fail++; $display("FAIL rmw_data: got %h exp 0", if3.data_r); end
    n_checks++; if (st3 !== IDLE) begin n_fail++; $display("FAIL rmw_state: got %b exp %b", st3, IDLE); end
    @(posedge clk); #1;
    req3(1'b0, 32'd11, 4'h0, '0);
    idle3();
    n_checks++; if (wen_seen !== 1'b0) begin n_fail++; $display("FAIL rmw_wen: got write strobe, exp none"); end
    n_checks++; if (o3_idata !== old_w) begin n_fail++; $display("FAIL rmw_old: got %h exp %h", o3_idata, old_w); end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    seed = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      ref0[i] = init_word(i, seed);
      ref3[i] = init_word(i, seed);
    end
    mem_init = 1'b1;
    reset = 1'b1;
    if0.en = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.be = '0; if0.data_w = '0;
    if3.en = 1'b0; if3.we = 1'b0; if3.addr = '0; if3.be = '0; if3.data_w = '0;
    clear_models();
    @(posedge clk); #1;
    mem_init = 1'b0;

    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_out_of_range();
    test_random0();
    test_wait_states();
    test_reset_mid_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_sram_responder.md
Name: imem_sram_responder

Overview:
- Memory-side endpoint of the Ram_if request/response protocol: receives requests from a client and drives one tc65nm single-port SRAM macro (active-low controls).
- Adds a configurable number of wait states and signals them on `delay`.
- Holds read data stable until the next accepted read, and flags out-of-range accesses.
- Sits below imem/dmem adapters, in place of a behavioural memory model.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, client word-address width.
- SRAM_DEPTH, 4096, macro words; SRAM_AW = $clog2(SRAM_DEPTH).
- WAIT_STATES, 0, extra stall cycles per request, 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  request valid; client holds addr/we/be/data_w stable while delay=1
- addr  in  ADDR_WIDTH  word address
- we  in  1  1 = write, 0 = read
- be  in  DATA_WIDTH/8  byte enables, active-high
- data_w  in  DATA_WIDTH  write data
- data_r  out  DATA_WIDTH  read data
- delay  out  1  stall; request accepted in a cycle with en=1 and delay=0
- err  out  1  one-cycle pulse, one cycle after acceptance of an out-of-range request
- sram_csn  out  1  macro chip select, active-low
- sram_wen  out  1  macro write enable, active-low
- sram_bwen  out  DATA_WIDTH  per-bit write mask, active-low
- sram_a  out  SRAM_AW  macro address
- sram_d  out  DATA_WIDTH  macro write data
- sram_q  in  DATA_WIDTH  macro read data, valid one cycle after a read-enabled edge

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state is cleared on the rising edge with reset=1.
- Reset values:
  - state=IDLE, cnt=0, delay=0, err=0, hold register=0, data_r=0.
  - sram_csn=1, sram_wen=1, sram_bwen=all ones.
- Range check: in_range = (addr < SRAM_DEPTH); sram_a = addr[SRAM_AW-1:0].
- FSM states:
  - IDLE:
    - en=1 and WAIT_STATES=0: delay=0, request accepted this cycle, stay IDLE.
    - en=1 and WAIT_STATES>0: delay=1 (combinational from en), go to WAIT with cnt=WAIT_STATES-1.
  - WAIT:
    - delay=1 while cnt!=0; cnt decrements each cycle.
    - When cnt==0: delay=0, request accepted, go to IDLE.
    - If en drops in WAIT (protocol violation), return to IDLE without acceptance, no write, no err.
- Macro drive:
  - sram_csn=0 in every cycle with en=1 and in_range, so the address is held through the wait states.
  - sram_wen=0 only in the accept cycle of an in-range write.
  - sram_bwen[8*i+7:8*i] = ~{8{be[i]}}; sram_d = data_w.
  - A write with be=0 is accepted and completes, but modifies no bits.
- Read response:
  - data_r is valid in the cycle after an accepted read: data_r = sram_q in that cycle, and the hold register captures sram_q.
  - In all later cycles data_r = hold register, until the next accepted read's response cycle.
  - Out-of-range read: data_r = 0 in the response cycle, hold register <= 0.
  - Writes never change data_r.
- Out of range: write dropped (sram_wen stays 1, sram_csn stays 1); err=1 in the cycle after acceptance.
- Back-to-back: with WAIT_STATES=0, one request per cycle.
  - Read followed by read: the second read's address is presented while the first's data is on data_r.
  - Read followed by write to the same address: data_r shows the pre-write value.
- Write-then-read to the same address: the read returns the new data (macro write completes before the next edge).
- Reset mid-WAIT: state returns to IDLE, delay=0 in the next cycle, the pending write is never issued, data_r=0.
- Throughput: one request per WAIT_STATES+1 cycles.

Decomposition:
- Package ram_resp_pkg:
  - typedef Resp_state {IDLE, WAIT};
  - function be_to_bwen(be), which expands byte enables to an active-low bit mask;
  - localparam MAX_WAIT_STATES = 15.
- Optional sub-module ram_resp_hold: the response-valid flag, hold register and data_r mux.
- The FSM and macro drive stay in the top module.

Test Plan:
- WAIT_STATES=0, reset then idle: delay=0, err=0, sram_csn=1, data_r=0 -> checked over 10 cycles.
- WAIT_STATES=0:
  - write addr=5, be=4'b1111, data_w=32'hDEADBEEF;
  - next cycle read addr=5 -> data_r=32'hDEADBEEF in the following cycle, held for 5 idle cycles.
- Partial write: addr=5, be=4'b0010, data_w=32'h0000_AA00, then read 5 -> 32'hDEADAAEF; sram_bwen during the write = 32'hFFFF00FF.
- WAIT_STATES=3, read addr=7:
  - delay=1 for exactly 3 cycles starting with the en cycle;
  - acceptance in the 4th cycle; data_r valid in the 5th;
  - sram_csn=0 in all 4 request cycles.
- SRAM_DEPTH=4096:
  - write addr=4096 -> sram_wen never 0, err=1 one cycle after acceptance;
  - read addr=5000 -> data_r=0, err pulse.
- WAIT_STATES=3, write issued, reset asserted in the 2nd delay cycle -> no sram_wen=0 ever, delay=0 after reset, a subsequent read of that address returns its old value.
